// File: rtl/ifu_inst_buffer.sv
// ---------------------------------------------------------------------------
// ifu_inst_buffer
//
// Instruction prefetch buffer between the fetch unit and decode. Fetched
// instruction/address pairs are queued in a small circular FIFO. The head
// entry is presented to decode as inst_o / inst_addr_o. A control-flow flush
// drops every queued entry and also drops the push offered in the same cycle.
//
// Configuration macro:
//   IBUF_BYPASS_EN - When defined, an empty buffer forwards the offered push
//                    straight to the outputs in the same cycle. If decode is
//                    not stalled, the instruction is consumed without being
//                    written. When undefined, the latency is a strict one
//                    cycle and there is no combinational push->inst path.
//
// Parameters:
//   DEPTH  - number of entries (a power of two, at least 2)
//   INST_W - instruction width
//   ADDR_W - instruction address width
//
// Ports:
//   clk, rst_n    - core clock, asynchronous active-low reset
//   flush_i       - discard all entries and the same-cycle push
//   stall_i       - decode hold; the head entry is not consumed
//   push_valid_i  - fetch data valid
//   push_ready_o  - buffer can accept a push (registered state only)
//   push_inst_i   - fetched instruction
//   push_addr_i   - fetched instruction address
//   inst_valid_o  - head entry valid toward decode
//   inst_o        - head instruction, or NOP (addi x0,x0,0) when not valid
//   inst_addr_o   - head address, or 0 when not valid
//   count_o       - current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ifu_inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     stall_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [INST_W-1:0]        push_inst_i,
  input  logic [ADDR_W-1:0]        push_addr_i,
  output logic                     inst_valid_o,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ifu_inst_buffer: DEPTH must be a power of two and at least 2");
  end

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          push_fire;
  logic          pop_fire;

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // Ready is based only on registered state. A pop in this cycle does not
  // open a slot until the next cycle, so there is no ready->valid loop back
  // into fetch.
  assign push_ready_o = !full;
  assign count_o      = wr_ptr_reg - rd_ptr_reg;

`ifdef IBUF_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = empty && push_valid_i && !flush_i;

  // A bypassed instruction taken directly by decode never enters the array.
  // If decode is stalled, it is stored normally and stays at the head.
  assign push_fire = push_valid_i && !full && !flush_i && !(bypass_hit && !stall_i);
  assign pop_fire  = !empty && !stall_i && !flush_i;

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = NOP_INST;
    inst_addr_o  = '0;
    if (!empty) begin
      inst_valid_o = 1'b1;
      inst_o       = inst_mem[rd_idx];
      inst_addr_o  = addr_mem[rd_idx];
    end else if (bypass_hit) begin
      inst_valid_o = 1'b1;
      inst_o       = push_inst_i;
      inst_addr_o  = push_addr_i;
    end
  end
`else
  assign push_fire = push_valid_i && !full && !flush_i;
  assign pop_fire  = !empty && !stall_i && !flush_i;

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = NOP_INST;
    inst_addr_o  = '0;
    if (!empty) begin
      inst_valid_o = 1'b1;
      inst_o       = inst_mem[rd_idx];
      inst_addr_o  = addr_mem[rd_idx];
    end
  end
`endif

  // A flush overrides any push or pop in the same cycle and returns both
  // pointers to the origin.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + PW'(push_fire);
    rd_ptr_next = rd_ptr_reg + PW'(pop_fire);
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // The storage array is not reset, because its contents are only read
  // behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      inst_mem[wr_idx] <= push_inst_i;
      addr_mem[wr_idx] <= push_addr_i;
    end
  end

endmodule

// File: doc/ifu_inst_buffer.md
Name: ifu_inst_buffer

Overview:
Instruction prefetch buffer between the fetch unit and the decode stage. It queues fetched instruction/address pairs in a small circular FIFO and presents the head entry to decode as inst_o / inst_addr_o. It decouples fetch-bus latency from decode stalls, and drops all queued entries on a control-flow flush (jump, branch mispredict, trap).

Parameters:
DEPTH, 4, number of entries; must be a power of two and at least 2
INST_W, 32, instruction width in bits (`INST_DATA_WIDTH)
ADDR_W, 32, instruction address width in bits (`INST_ADDR_WIDTH)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  discard all entries and the same-cycle push (from ctrl jump/trap)
stall_i  input  1  decode hold; head entry is not consumed while high
push_valid_i  input  1  fetch data valid
push_ready_o  output  1  buffer can accept a push this cycle
push_inst_i  input  INST_W  fetched instruction
push_addr_i  input  ADDR_W  fetched instruction address
inst_valid_o  output  1  head entry valid toward decode
inst_o  output  INST_W  head instruction; NOP 0x00000013 when not valid
inst_addr_o  output  ADDR_W  head address; 0 when not valid
count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry register array. Write pointer and read pointer are each $clog2(DEPTH)+1 bits wide; the MSB acts as a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = low bits equal AND MSBs differ.
- Reset (rst_n low, async): wr_ptr = rd_ptr = 0, count_o = 0, inst_valid_o = 0, inst_o = 0x00000013, inst_addr_o = 0, push_ready_o = 1. Array contents are don't-care.
- push_ready_o = !full, derived from registered state only. A same-cycle pop does NOT free a slot for a same-cycle push.
- Push: when push_valid_i && push_ready_o && !flush_i, write mem[wr_ptr] and increment wr_ptr, which wraps naturally.
- Pop: when inst_valid_o && !stall_i && !flush_i, increment rd_ptr.
- Outputs come combinationally from mem[rd_ptr] when not empty; otherwise the NOP and zero address defaults apply.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 at the earliest.
- Simultaneous push and pop: both pointers advance and count_o is unchanged.
- Push with pop when full: push_ready_o is 0, so only the pop happens. The freed slot is visible as ready in the next cycle.
- Flush has the highest priority. On the next edge wr_ptr = rd_ptr = 0 and count_o = 0. The same-cycle push and pop are ignored, and in the following cycle inst_valid_o = 0.
- Stall while empty: no effect. Pushes still fill the buffer.
- count_o = wr_ptr - rd_ptr (modular subtraction), range 0..DEPTH.
- Invariant: no entry is lost or duplicated. Every accepted push reaches the outputs exactly once unless a flush occurs.

Optional Feature:
IBUF_BYPASS_EN
- Defined: if the buffer is empty and push_valid_i && !flush_i, the outputs show the push data in the same cycle with inst_valid_o = 1.
  - If stall_i is also low, the instruction is consumed directly: no write, and the pointers stay unchanged.
  - If stall_i is high, the entry is written normally and is held at the head.
- Not defined: strict 1-cycle latency as above, with no combinational path from push_* to inst_*.

Test Plan:
- Reset with rst_n low mid-stream after 3 pushes -> immediately count_o = 0, inst_valid_o = 0, inst_o = 0x00000013, push_ready_o = 1.
- Push addr 0x80000000/0x80000004/0x80000008 on consecutive cycles with stall_i = 0 -> the outputs present each entry in order, one cycle after its push; count_o never exceeds 1.
- Hold stall_i = 1 and push 5 entries with DEPTH = 4 -> push_ready_o drops after the 4th push, the 5th is held by fetch, and count_o = 4. Release stall -> the entries pop in order 0..3 and the 5th is accepted one cycle after the first pop.
- Wrap-around: 10 push/pop pairs with 2 entries resident -> addresses emerge strictly in order across the pointer wrap, and count_o stays at 2.
- flush_i asserted while count_o = 3 and push_valid_i = 1 -> next cycle count_o = 0 and inst_valid_o = 0. The pushed entry never appears, and the next push after flush is the first entry output.
- With IBUF_BYPASS_EN, empty, push 0x00100093 @0x80000010 with stall_i = 0 -> inst_valid_o = 1 in the same cycle and count_o remains 0. Without the macro -> valid appears one cycle later.
